// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 signed convolution over a raster-order frame: two line buffers,
// a 3x3 window, a two-stage MAC pipeline and a backpressured output register.
module conv3x3_stream_engine #(
  parameter int DW    = 16,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int SHIFT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [9*DW-1:0] weight,
  input  logic [DW-1:0]   in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done
);
  localparam int ACC_W = 2*DW + 4;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int NOUT  = (IMG_W-2)*(IMG_H-2);
  localparam int OW    = $clog2(NOUT+1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [OW-1:0]          out_cnt;
  logic signed [DW-1:0]   wgt      [9];
  logic signed [DW-1:0]   lb0      [IMG_W];
  logic signed [DW-1:0]   lb1      [IMG_W];
  logic signed [DW-1:0]   win      [9];
  logic signed [DW-1:0]   win_next [9];
  logic signed [2*DW-1:0] prod     [9];
  logic                   s1_valid;
  logic                   advance;
  logic                   accept;
  logic                   out_hs;
  logic                   last_pix;
  logic                   win_ok;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic [DW-1:0]          sat_val;

  // Handshakes: a word moves on a rising edge where valid & ready are both high;
  // a producer holding valid keeps its data stable until that edge.
  assign advance  = !out_valid || out_ready;
  assign in_ready = (state == RUN) && advance;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign last_pix = (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));
  assign win_ok   = (row >= RW'(2)) && (col >= CW'(2));

  // Window after shifting in the current pixel; index k = 3*r + c, k=8 newest.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_next[3*r]   = win[3*r+1];
      win_next[3*r+1] = win[3*r+2];
    end
    win_next[2] = lb1[col];
    win_next[5] = lb0[col];
    win_next[8] = $signed(in_data);
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < 9; k++) acc = acc + ACC_W'(prod[k]);
    shifted = acc >>> SHIFT;
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[DW-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[DW-1:0];
    else                        sat_val = shifted[DW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      out_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int k = 0; k < 9; k++) wgt[k] <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (col == CW'(IMG_W-1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (out_hs) out_cnt <= out_cnt + OW'(1);
      case (state)
        IDLE: if (start) begin
          for (int k = 0; k < 9; k++) wgt[k] <= $signed(weight[k*DW +: DW]);
          col     <= '0;
          row     <= '0;
          out_cnt <= '0;
          busy    <= 1'b1;
          state   <= RUN;
        end
        RUN: if (accept && last_pix) state <= FLUSH;
        FLUSH: if (out_hs && out_cnt == OW'(NOUT-1)) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Everything downstream of the window freezes while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
      for (int k = 0; k < 9; k++) begin
        win[k]  <= '0;
        prod[k] <= '0;
      end
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        lb0[col] <= $signed(in_data);
        lb1[col] <= lb0[col];
        for (int k = 0; k < 9; k++) win[k] <= win_next[k];
      end
      if (advance) begin
        for (int k = 0; k < 9; k++) prod[k] <= (2*DW)'(win_next[k]) * (2*DW)'(wgt[k]);
        s1_valid  <= accept && win_ok;
        out_valid <= s1_valid;
        if (s1_valid) out_data <= sat_val;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Bench for conv3x3_stream_engine: two instances (SHIFT 0 and 2) share the
// stimulus; outputs are scored against a direct 3x3 convolution of the frame.
module tb_conv3x3_stream_engine;
  localparam int DW   = 16;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W*H;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [9*DW-1:0] weight = '0;
  logic [DW-1:0]   in_data = '0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            in_ready, out_valid, busy, done;
  logic [DW-1:0]   out_data;
  logic            in_ready_s, out_valid_s, busy_s, done_s;
  logic [DW-1:0]   out_data_s;

  always #5 clk = ~clk;

  conv3x3_stream_engine #(.DW(DW), .IMG_W(W), .IMG_H(H), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .weight(weight),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  conv3x3_stream_engine #(.DW(DW), .IMG_W(W), .IMG_H(H), .SHIFT(2)) dut_sh (
    .clk(clk), .rst(rst), .start(start), .weight(weight),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s),
    .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .busy(busy_s), .done(done_s)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rmode = 0;
  bit flushing = 1'b0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_hs_cyc = -1;
  int first_valid_cyc = -1;
  int acc_cyc = -1;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_s_q[$];
  logic signed [DW-1:0] img[NPIX];
  logic signed [DW-1:0] kw[9];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain valid-only 3x3 convolution, shift, clamp.
  function automatic logic [DW-1:0] sat(input longint v);
    longint mx, mn;
    longint r;
    mx = (longint'(1) << (DW-1)) - 1;
    mn = -mx - 1;
    r = (v > mx) ? mx : ((v < mn) ? mn : v);
    return r[DW-1:0];
  endfunction

  task automatic build_model();
    longint acc;
    exp_q.delete();
    exp_s_q.delete();
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        acc = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            acc += longint'(img[(r-2+i)*W + (c-2+j)]) * longint'(kw[3*i+j]);
        exp_q.push_back(sat(acc));
        exp_s_q.push_back(sat(acc >>> 2));
      end
  endtask

  always @(posedge clk) cyc++;

  // out_ready patterns: 0 always ready, 1 repeating 1,0,0,1, 2 random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_data", out_data, prev_data);
        chk("hold_valid", out_valid, 1);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (!busy || flushing) chk("idle_in_ready", in_ready, 0);
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_out", out_valid, 0);
        else begin
          chk("out_data", out_data, exp_q.pop_front());
          if (exp_q.size() == 0) last_hs_cyc = cyc;
        end
      end
      if (out_valid_s && out_ready) begin
        if (exp_s_q.size() == 0) chk("extra_out_sh", out_valid_s, 0);
        else chk("out_data_sh", out_data_s, exp_s_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        flushing = 1'b0;
        chk("done_out_valid", out_valid, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic junk_weight();
    for (int k = 0; k < 9; k++) weight[k*DW +: DW] = DW'($urandom);
  endtask

  task automatic run_frame(input int gap_lo, input int gap_hi, input bit restart,
                           input int stop_after, input bit check_lat);
    int n;
    int done_before;
    first_valid_cyc = -1;
    acc_cyc = -1;
    build_model();
    done_before = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 0; k < 9; k++) weight[k*DW +: DW] = kw[k];
    @(posedge clk); #1;
    start = 1'b0;
    junk_weight();
    for (int p = 0; p < NPIX; p++) begin
      if (p == stop_after) return;
      in_valid = 1'b1;
      in_data  = img[p];
      n = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        n++;
        if (n > 200) begin
          chk("in_ready_timeout", in_ready, 1);
          break;
        end
      end
      if (p == 2*W + 2) acc_cyc = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = DW'($urandom);
      if (restart && p == 5) begin
        start = 1'b1;
        junk_weight();
        @(posedge clk); #1;
        start = 1'b0;
      end
      repeat ($urandom_range(gap_lo, gap_hi)) @(posedge clk);
      #1;
    end
    flushing = 1'b1;
    n = 0;
    while (done_cnt == done_before && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - done_before, 1);
    chk("done_latency", done_cyc - last_hs_cyc, 1);
    chk("outputs_left", exp_q.size(), 0);
    chk("outputs_left_sh", exp_s_q.size(), 0);
    chk("busy_after", busy, 0);
    if (check_lat) chk("latency", first_valid_cyc - acc_cyc, 2);
  endtask

  task automatic set_ones();
    for (int p = 0; p < NPIX; p++) img[p] = DW'(p + 1);
    for (int k = 0; k < 9; k++) kw[k] = 1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int done_before;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    set_ones();
    rmode = 0;
    run_frame(0, 0, 1'b0, -1, 1'b1);

    rmode = 1;
    run_frame(0, 0, 1'b0, -1, 1'b0);

    for (int p = 0; p < NPIX; p++) img[p] = 16'sd32767;
    for (int k = 0; k < 9; k++) kw[k] = 16'sd32767;
    rmode = 2;
    run_frame(0, 1, 1'b0, -1, 1'b0);

    for (int k = 0; k < 9; k++) kw[k] = 0;
    kw[4] = -16'sd32768;
    run_frame(0, 1, 1'b0, -1, 1'b0);

    set_ones();
    rmode = 0;
    done_before = done_cnt;
    run_frame(0, 0, 1'b0, 7, 1'b0);
    rst = 1'b1;
    #1;
    check_reset("midframe_reset");
    exp_q.delete();
    exp_s_q.delete();
    flushing = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt - done_before, 0);
    run_frame(0, 0, 1'b0, -1, 1'b1);

    rmode = 2;
    run_frame(3, 3, 1'b1, -1, 1'b0);

    for (int f = 0; f < 4; f++) begin
      for (int p = 0; p < NPIX; p++)
        img[p] = (f % 2 == 0) ? DW'($urandom_range(0, 255) - 128) : DW'($urandom);
      for (int k = 0; k < 9; k++)
        kw[k] = (f % 2 == 0) ? DW'($urandom_range(0, 15) - 8) : DW'($urandom);
      run_frame(0, 2, 1'b0, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv3x3_stream_engine.md
Name: conv3x3_stream_engine

Overview:
- Parametrised streaming 3x3 convolution engine for the E203 accelerator datapath.
- Accepts a raster-order pixel stream over a valid/ready handshake and keeps IMG_W-wide line buffers internally.
- Computes signed 3x3 MACs against weights latched at start, then emits shifted, saturated outputs with backpressure.
- Signals completion after the last output of a frame; sits between the input DMA and the ofmap writeback.

Parameters:
DW, 16, pixel/weight/output width (signed two's complement)
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in rows (>=3)
SHIFT, 0, arithmetic right shift applied to accumulator before saturation (0..2*DW)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  frame start pulse; sampled only in IDLE
weight  input  9*DW  packed 3x3 kernel, index k = 3*row+col, k0 at LSBs; latched on accepted start
in_data  input  DW  pixel, raster order
in_valid  input  1  pixel valid
in_ready  output  1  engine accepts pixel this cycle
out_data  output  DW  convolution result
out_valid  output  1  result valid; held with out_data stable until out_ready
out_ready  input  1  downstream accepts result
busy  output  1  high in RUN/FLUSH
done  output  1  one-cycle pulse when frame complete

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=0, out_valid=0, out_data=0, busy=0, done=0; all counters, line buffers, window and pipeline valid bits cleared. Reset mid-frame abandons the frame with no done pulse.
- FSM states:
  - IDLE: start=1 latches weight, clears col/row counters, goes to RUN.
  - RUN: accepts pixels. After accepting pixel (IMG_H-1, IMG_W-1), goes to FLUSH.
  - FLUSH: drains the pipeline. When the last output handshakes (out_valid & out_ready), goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- Stall rule: advance = !out_valid | out_ready.
  - in_ready = (state==RUN) & advance.
  - A pixel is accepted when in_valid & in_ready.
  - Pipeline stages and the window register move only when advance=1; otherwise all hold.
- Counters: col wraps IMG_W-1 -> 0 and increments row. Accepted pixel shifts into the 3x3 window and two line buffers (depth IMG_W).
- Window validity: no padding. The window is valid when the accepted pixel has row>=2 and col>=2. Output count per frame = (IMG_W-2)*(IMG_H-2). Windows straddling a row wrap are never emitted.
- Window layout: window position w[r][c] with r,c in 0..2; w[2][2] is the newest pixel; w[r][c] multiplies weight k=3r+c.
- Pipeline, latency 2 cycles from acceptance to out_valid (no stall):
  - S1 registers 9 signed products (2*DW each).
  - S2 forms the sum in ACC_W = 2*DW+4 bits, arithmetic-shifts by SHIFT, saturates to [-2^(DW-1), 2^(DW-1)-1] and loads out_data/out_valid.
- Output register: out_valid is cleared by a handshake when no new result loads in the same cycle. Simultaneous handshake and new result: out_data is replaced, out_valid stays 1.
- done never asserts while out_valid=1.
- Weights are stable for the whole frame regardless of input changes after start.

Test Plan:
1. IMG_W=IMG_H=4, SHIFT=0, weights all 1, pixels 1..16, out_ready=1 -> outputs 54, 63, 90, 99 in order. done pulses once, 1 cycle after the last handshake.
2. Same frame, out_ready toggling 1,0,0,1 pattern -> identical 4 values. out_data is stable while out_valid & !out_ready. in_ready=0 during stalls. No pixel is lost.
3. DW=16, pixels all 32767, weights all 32767 -> every output 32767. Weight k4 = -32768, others 0, pixels 32767 -> every output -32768.
4. IMG_W=IMG_H=4, SHIFT=2, weights all 1, pixels 1..16 -> outputs 13, 15, 22, 24.
5. rst=1 asserted after 7 pixels accepted -> all outputs at reset values immediately. A new start then reproduces scenario 1 exactly.
6. start pulsed during RUN, and in_valid gaps of 3 cycles between pixels -> the second start is ignored; results match scenario 1; in_ready stays 0 in IDLE, FLUSH and DONE.
